// File: rtl/rvfi_pkg.sv
// Shared types for the RVFI retire-stream serializer.
package rvfi_pkg;

    localparam int ORDER_W = 64;

    typedef logic [31:0]        pc_t;
    typedef logic [ORDER_W-1:0] order_t;

endpackage

// File: rtl/commit_lane_compactor.sv
// Maps the sparse per-channel commit mask onto consecutive FIFO slots.
// Lane i lands at slot offset popcount(in_valid[i-1:0]); count is the total
// number of valid lanes. Also flags lanes whose next PC equals their own PC.
module commit_lane_compactor
    import rvfi_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*32-1:0]    in_pc_rdata,
    input  logic [NUM_CH*32-1:0]    in_pc_wdata,
    output logic [NUM_CH*CNT_W-1:0] offsets,
    output logic [CNT_W-1:0]        count,
    output logic [NUM_CH-1:0]       lane_halt
);

    logic [CNT_W-1:0] acc;

    // Running prefix count gives each valid lane its compacted slot offset.
    always_comb begin
        acc       = '0;
        offsets   = '0;
        lane_halt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            offsets[i*CNT_W +: CNT_W] = acc;
            acc = acc + CNT_W'(in_valid[i]);
            lane_halt[i] = (in_pc_wdata[i*32 +: 32] == in_pc_rdata[i*32 +: 32]);
        end
        count = acc;
    end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Serializes up to NUM_CH retire packets per cycle into a single in-order
// stream, stamping each with a 64-bit order number and sealing the stream
// once the halting instruction (pc_wdata == pc_rdata) has been emitted.
//
// Handshakes: the input side writes on a clock edge where in_ready=1, taking
// every lane whose in_valid bit is set (in_ready never looks at in_valid);
// the output side transfers the head on an edge where out_valid && out_ready,
// and out_valid/head data stay stable until that transfer.
module rvfi_commit_serializer
    import rvfi_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*32-1:0]    in_pc_rdata,
    input  logic [NUM_CH*32-1:0]    in_pc_wdata,
    input  logic [NUM_CH*PAYLOAD_W-1:0] in_payload,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_order,
    output logic [31:0]             out_pc_rdata,
    output logic [31:0]             out_pc_wdata,
    output logic [PAYLOAD_W-1:0]    out_payload,
    output logic                    out_halt,
    output logic                    halted,
    output logic                    overflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(NUM_CH + 1);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        pc_t                  pc_rdata;
        pc_t                  pc_wdata;
        logic                 halt;
    } fifo_entry_t;

    fifo_entry_t             mem [DEPTH];
    logic [PTR_W-1:0]        wptr, rptr;
    logic [PTR_W-1:0]        occ, free_slots;
    order_t                  order_q;
    logic                    halted_q, overflow_q;
    logic                    empty, full, push, pop;
    logic [NUM_CH*CNT_W-1:0] offsets;
    logic [CNT_W-1:0]        count;
    logic [NUM_CH-1:0]       lane_halt;
    logic [ADDR_W-1:0]       wr_addr    [NUM_CH];
    fifo_entry_t             lane_entry [NUM_CH];
    fifo_entry_t             head;

    commit_lane_compactor #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_compactor (
        .in_valid    (in_valid),
        .in_pc_rdata (in_pc_rdata),
        .in_pc_wdata (in_pc_wdata),
        .offsets     (offsets),
        .count       (count),
        .lane_halt   (lane_halt)
    );

    // Occupancy/flow-control status, derived from registered pointers only.
    always_comb begin
        occ        = wptr - rptr;
        free_slots = PTR_W'(DEPTH) - occ;
        empty      = (wptr == rptr);
        full       = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                     (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
        in_ready   = !halted_q && !rst && !full && (free_slots >= PTR_W'(NUM_CH));
        out_valid  = !empty && !halted_q;
        push       = in_ready && (|in_valid);
        pop        = out_valid && out_ready;
    end

    // Per-lane write slot and entry image.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_addr[i]    = wptr[ADDR_W-1:0] + ADDR_W'(offsets[i*CNT_W +: CNT_W]);
            lane_entry[i] = '{payload:  in_payload[i*PAYLOAD_W +: PAYLOAD_W],
                              pc_rdata: in_pc_rdata[i*32 +: 32],
                              pc_wdata: in_pc_wdata[i*32 +: 32],
                              halt:     lane_halt[i]};
        end
    end

    // Storage writes; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_valid[i]) begin
                    mem[wr_addr[i]] <= lane_entry[i];
                end
            end
        end
    end

    // Pointers, order counter and sticky halt/overflow flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            order_q    <= '0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (in_ready) begin
                wptr <= wptr + PTR_W'(count);
            end else if ((|in_valid) && !halted_q) begin
                overflow_q <= 1'b1;
            end
            if (pop) begin
                rptr    <= rptr + PTR_W'(1);
                order_q <= order_q + order_t'(1);
                if (head.halt) begin
                    halted_q <= 1'b1;
                end
            end
        end
    end

    // Head presentation; data is forced to zero whenever nothing is presented.
    always_comb begin
        head         = mem[rptr[ADDR_W-1:0]];
        out_order    = order_q;
        out_pc_rdata = out_valid ? head.pc_rdata : '0;
        out_pc_wdata = out_valid ? head.pc_wdata : '0;
        out_payload  = out_valid ? head.payload  : '0;
        out_halt     = out_valid && head.halt;
        halted       = halted_q;
        overflow     = overflow_q;
    end

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Directed bench for rvfi_commit_serializer (NUM_CH=2, DEPTH=8, PAYLOAD_W=256).
module tb_rvfi_commit_serializer;

    localparam int NUM_CH    = 2;
    localparam int DEPTH     = 8;
    localparam int PAYLOAD_W = 256;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_CH-1:0]           in_valid;
    logic [NUM_CH*32-1:0]        in_pc_rdata;
    logic [NUM_CH*32-1:0]        in_pc_wdata;
    logic [NUM_CH*PAYLOAD_W-1:0] in_payload;
    logic                        in_ready;
    logic                        out_valid;
    logic                        out_ready;
    logic [63:0]                 out_order;
    logic [31:0]                 out_pc_rdata;
    logic [31:0]                 out_pc_wdata;
    logic [PAYLOAD_W-1:0]        out_payload;
    logic                        out_halt;
    logic                        halted;
    logic                        overflow;

    int total = 0;
    int bad   = 0;

    rvfi_commit_serializer #(
        .NUM_CH    (NUM_CH),
        .DEPTH     (DEPTH),
        .PAYLOAD_W (PAYLOAD_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_pc_rdata  (in_pc_rdata),
        .in_pc_wdata  (in_pc_wdata),
        .in_payload   (in_payload),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_order    (out_order),
        .out_pc_rdata (out_pc_rdata),
        .out_pc_wdata (out_pc_wdata),
        .out_payload  (out_payload),
        .out_halt     (out_halt),
        .halted       (halted),
        .overflow     (overflow)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [PAYLOAD_W-1:0] pay_of(input logic [31:0] pc);
        return {8{pc ^ 32'hA5A5_0000}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = '0;
        in_pc_rdata = '0;
        in_pc_wdata = '0;
        in_payload  = '0;
    endtask

    task automatic set_lane(input int lane, input logic [31:0] pc_r, input logic [31:0] pc_w);
        in_valid[lane]                        = 1'b1;
        in_pc_rdata[lane*32 +: 32]            = pc_r;
        in_pc_wdata[lane*32 +: 32]            = pc_w;
        in_payload[lane*PAYLOAD_W +: PAYLOAD_W] = pay_of(pc_r);
    endtask

    task automatic apply_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b1;
        rst = 1'b1;
        #7;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (out_order !== 64'd0) begin bad++; $display("FAIL rst_out_order got=%0d want=0", out_order); end
        total++; if (out_halt !== 1'b0 || out_pc_rdata !== 32'd0 || out_pc_wdata !== 32'd0 || out_payload !== '0) begin
            bad++; $display("FAIL rst_data halt=%b pc_r=%h pc_w=%h want all 0", out_halt, out_pc_rdata, out_pc_wdata);
        end
        total++; if (halted !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL rst_flags halted=%b overflow=%b want 0/0", halted, overflow); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_single_stream();
        logic [31:0] pcs [3];
        pcs[0] = 32'h60; pcs[1] = 32'h64; pcs[2] = 32'h68;
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            set_lane(0, pcs[k], pcs[k] + 32'd4);
            if (k == 0) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid got=%b want=0", out_valid); end
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_order !== 64'(k) || out_pc_rdata !== pcs[k] ||
                out_pc_wdata !== pcs[k] + 32'd4 || out_payload !== pay_of(pcs[k]) || out_halt !== 1'b0) begin
                bad++;
                $display("FAIL single_%0d valid=%b order=%0d pc=%h want valid=1 order=%0d pc=%h", k, out_valid, out_order, out_pc_rdata, k, pcs[k]);
            end
        end
        idle_inputs();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_dual_commit();
        apply_reset();
        out_ready = 1'b1;
        set_lane(0, 32'h100, 32'h104);
        set_lane(1, 32'h104, 32'h108);
        tick();
        idle_inputs();
        total++; if (out_valid !== 1'b1 || out_pc_rdata !== 32'h100 || out_order !== 64'd0) begin
            bad++; $display("FAIL dual_first valid=%b pc=%h order=%0d want 1/100/0", out_valid, out_pc_rdata, out_order);
        end
        tick();
        total++; if (out_valid !== 1'b1 || out_pc_rdata !== 32'h104 || out_order !== 64'd1) begin
            bad++; $display("FAIL dual_second valid=%b pc=%h order=%0d want 1/104/1", out_valid, out_pc_rdata, out_order);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dual_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_sparse_lanes();
        apply_reset();
        out_ready = 1'b1;
        in_pc_rdata[31:0]         = 32'h500;
        in_pc_wdata[31:0]         = 32'h504;
        in_payload[PAYLOAD_W-1:0] = pay_of(32'h500);
        set_lane(1, 32'h200, 32'h204);
        in_valid = 2'b10;
        tick();
        idle_inputs();
        total++; if (out_valid !== 1'b1 || out_pc_rdata !== 32'h200 || out_order !== 64'd0 || out_payload !== pay_of(32'h200)) begin
            bad++; $display("FAIL sparse_head valid=%b pc=%h order=%0d want 1/200/0", out_valid, out_pc_rdata, out_order);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sparse_extra valid=%b pc=%h want valid=0", out_valid, out_pc_rdata); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_%0d got=%b want=1", k, in_ready); end
            idle_inputs();
            set_lane(0, 32'h400 + 32'(8*k), 32'h404 + 32'(8*k));
            set_lane(1, 32'h404 + 32'(8*k), 32'h408 + 32'(8*k));
            tick();
        end
        total++; if (in_ready !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL bp_full in_ready=%b overflow=%b want 0/0", in_ready, overflow);
        end
        idle_inputs();
        set_lane(0, 32'h900, 32'h904);
        set_lane(1, 32'h904, 32'h908);
        tick();
        idle_inputs();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow got=%b want=1", overflow); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_order !== 64'(k) || out_pc_rdata !== 32'h400 + 32'(4*k)) begin
                bad++;
                $display("FAIL bp_drain_%0d valid=%b order=%0d pc=%h want 1/%0d/%h", k, out_valid, out_order, out_pc_rdata, k, 32'h400 + 32'(4*k));
            end
            tick();
            if (k == 0) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_occ7_ready got=%b want=0", in_ready); end
            end
            if (k == 1) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_occ6_ready got=%b want=1", in_ready); end
            end
        end
        total++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++; $display("FAIL bp_after valid=%b overflow=%b want 0/1", out_valid, overflow);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        out_ready = 1'b0;
        set_lane(0, 32'h300, 32'h300);
        set_lane(1, 32'h304, 32'h308);
        tick();
        idle_inputs();
        set_lane(0, 32'h308, 32'h30C);
        tick();
        idle_inputs();
        total++; if (out_valid !== 1'b1 || out_halt !== 1'b1 || out_pc_rdata !== 32'h300 || out_order !== 64'd0) begin
            bad++; $display("FAIL halt_head valid=%b halt=%b pc=%h order=%0d want 1/1/300/0", out_valid, out_halt, out_pc_rdata, out_order);
        end
        out_ready = 1'b1;
        tick();
        total++; if (halted !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_halt !== 1'b0) begin
            bad++; $display("FAIL halt_seal halted=%b valid=%b in_ready=%b halt=%b want 1/0/0/0", halted, out_valid, in_ready, out_halt);
        end
        set_lane(0, 32'h310, 32'h314);
        set_lane(1, 32'h314, 32'h318);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || overflow !== 1'b0 || halted !== 1'b1) begin
                bad++; $display("FAIL halt_hold_%0d valid=%b in_ready=%b overflow=%b halted=%b want 0/0/0/1", k, out_valid, in_ready, overflow, halted);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b0;
        set_lane(0, 32'h600, 32'h604);
        set_lane(1, 32'h604, 32'h608);
        tick();
        idle_inputs();
        set_lane(0, 32'h608, 32'h60C);
        tick();
        idle_inputs();
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1 || out_order !== 64'd1 || out_pc_rdata !== 32'h604) begin
            bad++; $display("FAIL arst_pre valid=%b order=%0d pc=%h want 1/1/604", out_valid, out_order, out_pc_rdata);
        end
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_order !== 64'd0) begin
            bad++; $display("FAIL arst_immediate valid=%b in_ready=%b order=%0d want 0/0/0", out_valid, in_ready, out_order);
        end
        #1;
        rst = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL arst_empty valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        set_lane(0, 32'h700, 32'h704);
        tick();
        idle_inputs();
        total++; if (out_valid !== 1'b1 || out_order !== 64'd0 || out_pc_rdata !== 32'h700) begin
            bad++; $display("FAIL arst_restart valid=%b order=%0d pc=%h want 1/0/700", out_valid, out_order, out_pc_rdata);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_single_stream();
        test_dual_commit();
        test_sparse_lanes();
        test_backpressure();
        test_halt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rvfi_commit_serializer.md
Name: rvfi_commit_serializer

Overview:
- Multi-channel retire-stream serializer for the RVFI monitor path.
- Accepts up to NUM_CH commit packets per cycle from a superscalar or out-of-order writeback/retire stage and buffers them in a DEPTH-entry FIFO.
- Emits packets one per cycle in program order, stamped with a 64-bit order number.
- Detects the halt condition (pc_wdata == pc_rdata on a committed packet) and seals the stream after it.

Parameters:
- NUM_CH, 2, commit channels per cycle (1..4).
- DEPTH, 8, FIFO entries; power of two, DEPTH >= 2*NUM_CH.
- PAYLOAD_W, 256, opaque packet bits (inst, rs/rd addr+data, mem fields), passed through unmodified.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  NUM_CH  per-channel commit strobe; bit i = channel i
- in_pc_rdata  in  NUM_CH*32  per-channel PC of committing instruction
- in_pc_wdata  in  NUM_CH*32  per-channel next PC
- in_payload  in  NUM_CH*PAYLOAD_W  per-channel opaque packet
- in_ready  out  1  high when at least NUM_CH slots are free and the stream is not halted
- out_valid  out  1  head packet presented
- out_ready  in  1  consumer accepts head this cycle
- out_order  out  64  order number of head packet
- out_pc_rdata  out  32  head PC
- out_pc_wdata  out  32  head next PC
- out_payload  out  PAYLOAD_W  head payload
- out_halt  out  1  head packet is the halting instruction
- halted  out  1  sticky; set when the halt packet is dequeued
- overflow  out  1  sticky; protocol error flag

Behaviour:
- Reset (async, rst=1): FIFO empty; write and read pointers 0; order counter 0; halted=0; overflow=0. Outputs while in reset: out_valid=0, in_ready=0, out_order=0, out_halt=0, data outputs 0.
- Enqueue on clk rising edge when in_ready=1:
  - Valid lanes are compacted in ascending channel index; sparse masks are allowed (e.g. mask 2'b10 writes channel 1 only).
  - The write pointer advances by popcount(in_valid), modulo DEPTH.
  - Halt is computed per lane at enqueue (pc_wdata == pc_rdata) and stored as one bit per entry.
- Enqueue with in_valid != 0 and in_ready = 0:
  - Packets are dropped and overflow is set sticky, except when halted=1.
  - When halted=1, drops are silent and overflow is unchanged.
- in_ready = !halted && !rst && (free_slots >= NUM_CH). It is combinational from registered state only and never depends on in_valid.
- Dequeue:
  - out_valid = !empty && !halted.
  - The head leaves when out_valid && out_ready. The read pointer then advances by 1 and the order counter by 1.
  - out_order = order counter value before the increment (first packet = 0).
- Latency: a packet enqueued at edge t is visible at the head after edge t, i.e. in cycle t+1 at the earliest. There is no combinational in-to-out path.
- Simultaneous enqueue and dequeue in one cycle are allowed. Occupancy update = occ + popcount - deq. A full FIFO with a dequeue does not raise in_ready until the next cycle.
- Halt:
  - When the dequeued head has out_halt=1, halted is set at that edge.
  - After that: out_valid=0 and in_ready=0 permanently; remaining FIFO contents are discarded, not emitted.
  - Only rst clears halted.
- Wrap-around: pointers are log2(DEPTH)+1 bits; full/empty come from MSB comparison; occupancy = wptr - rptr.
- Order counter wraps at 2^64 with no flag.
- Reset asserted mid-stream: all state clears immediately (asynchronously). The order counter restarts at 0.

Decomposition:
- Package rvfi_pkg:
  - pc_t (32-bit) and order_t (64-bit).
  - The fifo_entry_t struct {payload, pc_rdata, pc_wdata, halt} is PAYLOAD_W-dependent, so it is declared as a local typedef in the module.
  - Constant ORDER_W=64.
- One sub-module, commit_lane_compactor:
  - Combinational; takes in_valid plus per-lane data.
  - Outputs the lane-to-slot offset vector and popcount.
  - The top level owns the FIFO storage, pointers, order counter and halt/overflow logic.

Test Plan:
- Single stream (NUM_CH=2, mask 2'b01 each cycle, pc_rdata 0x60,0x64,0x68; out_ready=1) -> out_valid rises one cycle after each write; out_order 0,1,2; out_pc_rdata matches.
- Dual commit (mask 2'b11, ch0 pc 0x100, ch1 pc 0x104) -> two consecutive outputs, 0x100 then 0x104, orders 0 then 1.
- Sparse lanes (mask 2'b10, ch1 pc 0x200) -> single output pc 0x200, order 0; ch0 payload never appears.
- Backpressure (DEPTH=8, out_ready=0, four cycles of mask 2'b11) -> occupancy 6 then 8; in_ready=0 once occupancy exceeds 6; a fifth write sets overflow=1. Raising out_ready drains exactly 8 packets with orders 0..7.
- Halt (packet pc_rdata=pc_wdata=0x300 followed by two more packets) -> halt packet emitted with out_halt=1; halted=1 on the next cycle; following packets never appear; in_ready stays 0; further in_valid does not set overflow.
- Async reset mid-drain (rst pulses between clock edges with 3 packets queued) -> out_valid=0 and in_ready=0 immediately. After release, the next packet emits with out_order=0.
